// File: rtl/mdio_receptor.sv
// ---------------------------------------------------------------------------
// mdio_receptor
//
// PHY-side Clause-22 MDIO frame decoder. Sits directly downstream of the MDIO
// frame generator, watches its mdc / mdio_out / mdio_oe, and services frames
// against an internal 32 x 16 register file. Read data is shifted back to the
// generator on mdio_in while mdio_in_oe is high.
//
// Frame (bit 31 first): ST[31:30]=01, OP[29:28] (01 write, 10 read),
// PHYAD[27:23], REGAD[22:18], TA[17:16] (ignored), DATA[15:0].
//
// Ports
//   clk         system clock, all logic on its rising edge
//   reset       synchronous, active-high
//   mdc         management clock, sampled in the clk domain
//   mdio_out    serial frame data from the generator
//   mdio_oe     high while the generator drives mdio_out
//   mdio_in     serial read data back to the generator (0 when not driving)
//   mdio_in_oe  high while this block drives mdio_in
//   wr_stb      one-clk pulse when a register write commits
//   wr_addr     register address of the last committed write
//   wr_data     data of the last committed write
//   frame_err   one-clk pulse on an aborted or illegal frame
//   busy        high whenever a frame is in progress
//
// Handshake: there is no valid/ready pair here. A frame bit is transferred
// exactly once, in the single clk cycle where mdc is high and was low on the
// previous clk (mdc rising edge); nothing is sampled or shifted otherwise.
//
// Build option
//   MDIO_PHYAD_CHECK_EN  when defined, frames whose PHYAD differs from
//                        PHY_ADDR are consumed silently (no write, no drive,
//                        no frame_err). When undefined PHYAD is ignored.
// ---------------------------------------------------------------------------
module mdio_receptor #(
    parameter logic [4:0]  PHY_ADDR    = 5'd1,
    parameter logic [15:0] REG_RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_out,
    input  logic        mdio_oe,
    output logic        mdio_in,
    output logic        mdio_in_oe,
    output logic        wr_stb,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic        busy
);

`ifdef MDIO_PHYAD_CHECK_EN
    localparam bit PHYAD_CHECK = 1'b1;
`else
    localparam bit PHYAD_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HEADER     = 2'd1,
        WRITE_DATA = 2'd2,
        READ_DATA  = 2'd3
    } state_t;

    state_t      state;
    logic        mdc_prev;
    logic        mdc_rise;
    logic [5:0]  bit_cnt;
    logic [15:0] shift_rx;
    logic [15:0] shift_tx;
    logic [4:0]  regad;
    logic        ignore_frame;
    logic [15:0] regs [32];

    // Receive word including the bit arriving on this edge. At the 16th edge
    // it is the complete header; at the 32nd edge it is the write data.
    logic [15:0] rx_next;
    logic [1:0]  hdr_st;
    logic [1:0]  hdr_op;
    logic [4:0]  hdr_phyad;
    logic [4:0]  hdr_regad;
    logic        hdr_legal;
    logic        hdr_foreign;

    assign mdc_rise    = mdc & ~mdc_prev;
    assign rx_next     = {shift_rx[14:0], mdio_out};
    assign hdr_st      = rx_next[15:14];
    assign hdr_op      = rx_next[13:12];
    assign hdr_phyad   = rx_next[11:7];
    assign hdr_regad   = rx_next[6:2];
    assign hdr_legal   = (hdr_st == 2'b01) && ((hdr_op == 2'b01) || (hdr_op == 2'b10));
    assign hdr_foreign = PHYAD_CHECK && (hdr_phyad != PHY_ADDR);

    assign mdio_in = mdio_in_oe & shift_tx[15];
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mdc_prev     <= 1'b0;
            bit_cnt      <= 6'd0;
            shift_rx     <= 16'h0000;
            shift_tx     <= 16'h0000;
            regad        <= 5'd0;
            ignore_frame <= 1'b0;
            mdio_in_oe   <= 1'b0;
            wr_stb       <= 1'b0;
            wr_addr      <= 5'd0;
            wr_data      <= 16'h0000;
            frame_err    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= REG_RST_VAL;
            end
        end else begin
            mdc_prev  <= mdc;
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;

            if (mdc_rise) begin
                case (state)
                    IDLE: begin
                        if (mdio_oe) begin
                            shift_rx <= rx_next;
                            bit_cnt  <= 6'd1;
                            state    <= HEADER;
                        end
                    end

                    HEADER: begin
                        if (!mdio_oe) begin
                            frame_err <= 1'b1;
                            bit_cnt   <= 6'd0;
                            state     <= IDLE;
                        end else begin
                            shift_rx <= rx_next;
                            bit_cnt  <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd15) begin
                                if (!hdr_legal) begin
                                    frame_err <= 1'b1;
                                    bit_cnt   <= 6'd0;
                                    state     <= IDLE;
                                end else begin
                                    regad        <= hdr_regad;
                                    ignore_frame <= hdr_foreign;
                                    if (hdr_op == 2'b01) begin
                                        state <= WRITE_DATA;
                                    end else begin
                                        // Foreign reads still walk the data
                                        // phase, just without driving.
                                        shift_tx   <= regs[hdr_regad];
                                        mdio_in_oe <= ~hdr_foreign;
                                        state      <= READ_DATA;
                                    end
                                end
                            end
                        end
                    end

                    WRITE_DATA: begin
                        if (!mdio_oe) begin
                            frame_err <= ~ignore_frame;
                            bit_cnt   <= 6'd0;
                            state     <= IDLE;
                        end else begin
                            shift_rx <= rx_next;
                            bit_cnt  <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd31) begin
                                if (!ignore_frame) begin
                                    regs[regad] <= rx_next;
                                    wr_stb      <= 1'b1;
                                    wr_addr     <= regad;
                                    wr_data     <= rx_next;
                                end
                                bit_cnt <= 6'd0;
                                state   <= IDLE;
                            end
                        end
                    end

                    READ_DATA: begin
                        // The generator has released the line; its mdio_oe
                        // carries no meaning here.
                        shift_tx <= {shift_tx[14:0], 1'b0};
                        bit_cnt  <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd31) begin
                            mdio_in_oe <= 1'b0;
                            bit_cnt    <= 6'd0;
                            state      <= IDLE;
                        end
                    end

                    default: begin
                        bit_cnt <= 6'd0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_receptor.sv
// ---------------------------------------------------------------------------
// tb_mdio_receptor
//
// Directed bench for mdio_receptor. Frames are driven with mdc = clk/4. A
// frame-level model (register array plus per-frame bookkeeping) predicts the
// outputs after every mdc edge; one compare process checks all outputs against
// it every clk. Hand-computed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_mdio_receptor;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mdc = 1'b0;
    logic        mdio_out = 1'b0;
    logic        mdio_oe = 1'b0;
    logic        mdio_in;
    logic        mdio_in_oe;
    logic        wr_stb;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic        busy;

    always #5 clk = ~clk;

    mdio_receptor #(
        .PHY_ADDR    (5'd1),
        .REG_RST_VAL (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mdc        (mdc),
        .mdio_out   (mdio_out),
        .mdio_oe    (mdio_oe),
        .mdio_in    (mdio_in),
        .mdio_in_oe (mdio_in_oe),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int stb_seen = 0;
    int err_seen = 0;
    int oe_cycles = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [15:0] model_regs [32];
    logic        exp_oe, exp_in, exp_busy, exp_stb, exp_err;
    logic [4:0]  exp_addr;
    logic [15:0] exp_data;
    bit          m_active;
    int          m_cnt;
    int          m_kind;      // 0 none, 1 write, 2 read, 3 foreign write, 4 foreign read
    logic [15:0] m_hdr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic [4:0]  m_regad;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;
        exp_oe = 0; exp_in = 0; exp_busy = 0; exp_stb = 0; exp_err = 0;
        exp_addr = 5'd0; exp_data = 16'h0000;
        m_active = 0; m_cnt = 0; m_kind = 0;
        m_hdr = 16'h0; m_wdata = 16'h0; m_rdata = 16'h0; m_regad = 5'd0;
    endtask

    task automatic model_end();
        m_active = 0; m_kind = 0; m_cnt = 0;
        exp_busy = 0; exp_oe = 0; exp_in = 0;
    endtask

    // Called right after the clk edge on which an mdc rising edge was seen.
    task automatic model_edge(input logic b, input logic oe);
        logic [1:0] st, op;
        logic [4:0] phy;
        bit for_us;
        if (!m_active) begin
            if (oe) begin
                m_active = 1; m_cnt = 1; m_hdr = {15'b0, b}; exp_busy = 1;
            end
            return;
        end
        m_cnt++;
        if (m_cnt <= 16) begin
            if (!oe) begin
                exp_err = 1; model_end(); return;
            end
            m_hdr = {m_hdr[14:0], b};
            if (m_cnt == 16) begin
                st = m_hdr[15:14]; op = m_hdr[13:12]; phy = m_hdr[11:7];
                m_regad = m_hdr[6:2];
                for_us = 1;
`ifdef MDIO_PHYAD_CHECK_EN
                for_us = (phy == 5'd1);
`endif
                if (st != 2'b01 || !(op == 2'b01 || op == 2'b10)) begin
                    exp_err = 1; model_end();
                end else if (op == 2'b01) begin
                    m_kind = for_us ? 1 : 3;
                end else begin
                    m_kind = for_us ? 2 : 4;
                    m_rdata = model_regs[m_regad];
                    if (for_us) begin
                        exp_oe = 1; exp_in = m_rdata[15];
                    end
                end
            end
        end else if (m_kind == 1 || m_kind == 3) begin
            if (!oe) begin
                if (m_kind == 1) exp_err = 1;
                model_end(); return;
            end
            m_wdata = {m_wdata[14:0], b};
            if (m_cnt == 32) begin
                if (m_kind == 1) begin
                    model_regs[m_regad] = m_wdata;
                    exp_stb = 1; exp_addr = m_regad; exp_data = m_wdata;
                end
                model_end();
            end
        end else begin
            if (m_cnt == 32) model_end();
            else if (m_kind == 2) exp_in = m_rdata[31 - m_cnt];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        exp_stb = 0;
        exp_err = 0;
    endtask

    // One mdc period (4 clks); s = mdio_in just after the edge is consumed.
    task automatic mdc_bit(input logic b, input logic oe, output logic s);
        mdio_out = b; mdio_oe = oe; mdc = 1'b1;
        tick();
        model_edge(b, oe);
        s = mdio_in;
        tick();
        mdc = 1'b0;
        tick();
        tick();
    endtask

    // Sends n_edges bits of f (bit 31 first). drop_at: edge number sent with
    // mdio_oe=0 (0 = none). rel: generator releases the line after edge 16.
    // rd collects mdio_in after edges 16..31.
    task automatic send_frame(input logic [31:0] f, input int n_edges, input int drop_at,
                              input bit rel, output logic [15:0] rd);
        logic s;
        logic oe;
        rd = 16'h0;
        for (int n = 1; n <= n_edges; n++) begin
            oe = 1'b1;
            if (n == drop_at) oe = 1'b0;
            if (rel && n > 16) oe = 1'b0;
            mdc_bit(rel && n > 16 ? 1'b0 : f[32-n], oe, s);
            if (n >= 16 && n <= 31) rd = {rd[14:0], s};
        end
        mdio_oe = 1'b0;
        mdio_out = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] ra, output logic [15:0] val);
        logic [31:0] f;
        f = {2'b01, 2'b10, 5'd1, ra, 2'b00, 16'h0000};
        send_frame(f, 32, 0, 1'b1, val);
    endtask

    task automatic do_reset();
        reset = 1'b1; mdc = 1'b0; mdio_oe = 1'b0; mdio_out = 1'b0;
        tick();
        model_reset();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // ---------------- scoreboard / compare process ----------------
    initial begin
        wait (chk_en);
        forever begin
            @(posedge clk);
            #2;
            chk("mdio_in_oe", {31'b0, mdio_in_oe}, {31'b0, exp_oe});
            chk("mdio_in",    {31'b0, mdio_in},    {31'b0, exp_in});
            chk("busy",       {31'b0, busy},       {31'b0, exp_busy});
            chk("wr_stb",     {31'b0, wr_stb},     {31'b0, exp_stb});
            chk("frame_err",  {31'b0, frame_err},  {31'b0, exp_err});
            chk("wr_addr",    {27'b0, wr_addr},    {27'b0, exp_addr});
            chk("wr_data",    {16'b0, wr_data},    {16'b0, exp_data});
            if (wr_stb) stb_seen++;
            if (frame_err) err_seen++;
            if (mdio_in_oe) oe_cycles++;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] rd;
        int stb0, err0, oe0;

        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_en = 1'b1;

        chk("rst_oe",   {31'b0, mdio_in_oe}, 32'd0);
        chk("rst_busy", {31'b0, busy},       32'd0);
        chk("rst_data", {16'b0, wr_data},    32'd0);

        // Reset value of reg 5
        read_reg(5'd5, rd);
        chk("read5_rst", {16'b0, rd}, 32'h0000);

        // Write reg 3 = ABCD
        stb0 = stb_seen; err0 = err_seen;
        send_frame(32'h508E_ABCD, 32, 0, 1'b0, rd);
        tick();
        chk("wr_stb_cnt",  stb_seen - stb0, 32'd1);
        chk("wr_err_cnt",  err_seen - err0, 32'd0);
        chk("wr_addr_lit", {27'b0, wr_addr}, 32'd3);
        chk("wr_data_lit", {16'b0, wr_data}, 32'h0000_ABCD);
        chk("model_reg3",  {16'b0, model_regs[3]}, 32'h0000_ABCD);

        // Readback reg 3
        oe0 = oe_cycles;
        read_reg(5'd3, rd);
        tick();
        chk("read3_bits",  {16'b0, rd}, 32'h0000_ABCD);
        chk("read3_oecyc", oe_cycles - oe0, 32'd64);
        chk("read3_busy",  {31'b0, busy}, 32'd0);

        // Bad ST header only; then a valid write is accepted
        stb0 = stb_seen; err0 = err_seen;
        send_frame(32'h108E_FFFF, 16, 0, 1'b0, rd);
        tick();
        chk("badst_err", err_seen - err0, 32'd1);
        chk("badst_stb", stb_seen - stb0, 32'd0);
        stb0 = stb_seen;
        send_frame(32'h509E_1357, 32, 0, 1'b0, rd);
        tick();
        chk("next_stb",  stb_seen - stb0, 32'd1);
        chk("next_data", {16'b0, wr_data}, 32'h0000_1357);

        // Write aborted at edge 20
        stb0 = stb_seen; err0 = err_seen;
        send_frame(32'h508E_5555, 20, 20, 1'b0, rd);
        tick();
        chk("abort_err", err_seen - err0, 32'd1);
        chk("abort_stb", stb_seen - stb0, 32'd0);
        read_reg(5'd3, rd);
        chk("abort_reg3", {16'b0, rd}, 32'h0000_ABCD);

        // Frame addressed to PHYAD 2
        stb0 = stb_seen; err0 = err_seen;
        send_frame(32'h510E_1234, 32, 0, 1'b0, rd);
        tick();
        chk("phy2_err",  err_seen - err0, 32'd0);
        chk("phy2_busy", {31'b0, busy}, 32'd0);
        read_reg(5'd3, rd);
`ifdef MDIO_PHYAD_CHECK_EN
        chk("phy2_stb",  stb_seen - stb0, 32'd0);
        chk("phy2_reg3", {16'b0, rd}, 32'h0000_ABCD);
`else
        chk("phy2_stb",  stb_seen - stb0, 32'd1);
        chk("phy2_reg3", {16'b0, rd}, 32'h0000_1234);
`endif

        // Reset during a read at edge 24
        send_frame(32'h608C_0000, 24, 0, 1'b1, rd);
        chk("pre_rst_oe", {31'b0, mdio_in_oe}, 32'd1);
        err0 = err_seen;
        do_reset();
        chk("mid_rst_oe",  {31'b0, mdio_in_oe}, 32'd0);
        chk("mid_rst_err", err_seen - err0, 32'd0);
        read_reg(5'd3, rd);
        chk("rst_reg3", {16'b0, rd}, 32'h0000);
        read_reg(5'd7, rd);
        chk("rst_reg7", {16'b0, rd}, 32'h0000);

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
